// File: rtl/stage3_exec_mdu_if.sv
// Operand/control bundle between operand fetch and the execute stage.
// The master side drives the instruction and the slave side returns results.
interface stage3_exec_mdu_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            valid_in;
  logic [3:0]      op;
  logic            use_rs2;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;
  logic [5:0]      branch_type;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] instruction_addr;
  logic [XLEN-1:0] jal_addr;
  logic [XLEN-1:0] eval;
  logic            eval_valid;
  logic            redirect;
  logic            busy;

  modport master (
    output stall, valid_in, op, use_rs2, is_branch, is_jal, is_jalr, branch_type,
           rs1_val, rs2_val, imm,
    input  instruction_addr, jal_addr, eval, eval_valid, redirect, busy
  );

  modport slave (
    input  stall, valid_in, op, use_rs2, is_branch, is_jal, is_jalr, branch_type,
           rs1_val, rs2_val, imm,
    output instruction_addr, jal_addr, eval, eval_valid, redirect, busy
  );
endinterface

// File: rtl/stage3_exec_mdu.sv
// Execute stage: single-cycle ALU, branch/jump resolution, PC register and an
// iterative shift-add multiplier / restoring divider sequenced by a small FSM.
module stage3_exec_mdu #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 4
) (
  input logic              clock,
  input logic              reset,
  stage3_exec_mdu_if.slave bus
);
  localparam int              SW        = $clog2(XLEN);
  localparam logic [SW-1:0]   LAST_STEP = SW'(XLEN - 1);
  localparam logic [XLEN-1:0] STEP      = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     cnt_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   eval_q;
  logic              eval_valid_q;
  logic [XLEN-1:0]   divisor_q;
  logic              div_q;
  logic              hi_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN-1:0]   pc_d;

  logic [XLEN-1:0]   arg2_s;
  logic [SW-1:0]     shamt_s;
  logic [XLEN-1:0]   alu_s;
  logic [XLEN-1:0]   jal_addr_s;
  logic [XLEN-1:0]   mdu_res_s;
  logic [XLEN:0]     add_s;
  logic [XLEN:0]     rem_shift_s;
  logic [XLEN:0]     trial_s;
  logic [5:0]        conds_s;
  logic              is_mdu_s;
  logic              slt_s;
  logic              sltu_s;
  logic              eq_br_s;
  logic              lt_br_s;
  logic              ltu_br_s;
  logic              taken_s;
  logic              busy_s;
  logic              accept_s;

  assign arg2_s   = bus.use_rs2 ? bus.rs2_val : bus.imm;
  assign shamt_s  = arg2_s[SW-1:0];
  assign is_mdu_s = (bus.op >= 4'd10) && (bus.op <= 4'd13);
  assign slt_s    = $signed(bus.rs1_val) < $signed(arg2_s);
  assign sltu_s   = bus.rs1_val < arg2_s;

  // Single-cycle ALU; unused encodings 14/15 fall through to ADD.
  always_comb begin
    alu_s = '0;
    case (bus.op)
      4'd1:    alu_s = bus.rs1_val - arg2_s;
      4'd2:    alu_s = bus.rs1_val & arg2_s;
      4'd3:    alu_s = bus.rs1_val | arg2_s;
      4'd4:    alu_s = bus.rs1_val ^ arg2_s;
      4'd5:    alu_s = bus.rs1_val << shamt_s;
      4'd6:    alu_s = bus.rs1_val >> shamt_s;
      4'd7:    alu_s = $unsigned($signed(bus.rs1_val) >>> shamt_s);
      4'd8:    alu_s = {{(XLEN-1){1'b0}}, slt_s};
      4'd9:    alu_s = {{(XLEN-1){1'b0}}, sltu_s};
      default: alu_s = bus.rs1_val + arg2_s;
    endcase
  end

  assign eq_br_s  = bus.rs1_val == bus.rs2_val;
  assign lt_br_s  = $signed(bus.rs1_val) < $signed(bus.rs2_val);
  assign ltu_br_s = bus.rs1_val < bus.rs2_val;
  assign conds_s  = {~ltu_br_s, ltu_br_s, ~lt_br_s, lt_br_s, ~eq_br_s, eq_br_s};
  assign taken_s  = bus.is_branch & (|(bus.branch_type & conds_s));

  // Reset also masks the input-driven busy term so upstream sees idle at once.
  assign busy_s     = reset & ((state_q == ST_RUN) |
                               ((state_q == ST_IDLE) & bus.valid_in & is_mdu_s));
  assign accept_s   = bus.valid_in & ~bus.stall & ~busy_s;
  assign jal_addr_s = pc_q + STEP;

  // Next PC for an accepted instruction.
  always_comb begin
    pc_d = jal_addr_s;
    if (bus.is_jal | taken_s) begin
      pc_d = pc_q + bus.imm;
    end else if (bus.is_jalr) begin
      pc_d = (bus.rs1_val + bus.imm) & JALR_MASK;
    end else begin
      pc_d = jal_addr_s;
    end
  end

  // acc_q is {high, low}: product/multiplier for MUL, remainder/quotient for DIV.
  assign add_s       = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divisor_q} : '0);
  assign rem_shift_s = acc_q[2*XLEN-1:XLEN-1];
  assign trial_s     = rem_shift_s - {1'b0, divisor_q};
  assign mdu_res_s   = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

  // One multiply or divide iteration.
  always_comb begin
    acc_d = acc_q;
    if (div_q) begin
      if (!trial_s[XLEN]) begin
        acc_d = {trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_d = {rem_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_d = {add_s, acc_q[XLEN-1:1]};
    end
  end

  // Execute FSM with PC, result and MDU registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pc_q         <= RESET_PC;
      eval_q       <= '0;
      eval_valid_q <= 1'b0;
      divisor_q    <= '0;
      div_q        <= 1'b0;
      hi_q         <= 1'b0;
      acc_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.stall) begin
            if (bus.valid_in && is_mdu_s) begin
              acc_q        <= {{XLEN{1'b0}}, bus.rs1_val};
              divisor_q    <= arg2_s;
              div_q        <= bus.op[2];
              hi_q         <= bus.op[0];
              cnt_q        <= '0;
              eval_valid_q <= 1'b0;
              state_q      <= ST_RUN;
            end else if (accept_s) begin
              eval_q       <= alu_s;
              eval_valid_q <= 1'b1;
              pc_q         <= pc_d;
            end else begin
              eval_valid_q <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          acc_q        <= acc_d;
          cnt_q        <= cnt_q + {{(SW-1){1'b0}}, 1'b1};
          eval_valid_q <= 1'b0;
          if (cnt_q == LAST_STEP) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!bus.stall) begin
            eval_q       <= mdu_res_s;
            eval_valid_q <= 1'b1;
            state_q      <= ST_IDLE;
            if (accept_s) begin
              pc_q <= pc_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.instruction_addr = pc_q;
  assign bus.jal_addr         = jal_addr_s;
  assign bus.eval             = eval_q;
  assign bus.eval_valid       = eval_valid_q;
  assign bus.redirect         = accept_s & (bus.is_jal | bus.is_jalr | taken_s);
  assign bus.busy             = busy_s;
endmodule

// File: tb/tb_stage3_exec_mdu.sv
// Directed plus randomized bench for stage3_exec_mdu against an arithmetic
// reference model of the execute stage.
module tb_stage3_exec_mdu;
  localparam int XLEN = 32;

  logic        clock = 1'b0;
  logic        reset;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_pc;
  logic [31:0] model_eval;

  stage3_exec_mdu_if #(.XLEN(XLEN)) bus ();

  stage3_exec_mdu #(.XLEN(XLEN), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      4'd12:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd13:   return (b == 32'd0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [31:0] a, input logic [31:0] b,
                                     input logic [5:0] bt);
    return (bt[0] && (a == b)) || (bt[1] && (a != b)) ||
           (bt[2] && ($signed(a) < $signed(b))) || (bt[3] && !($signed(a) < $signed(b))) ||
           (bt[4] && (a < b)) || (bt[5] && !(a < b));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in    = 1'b0;
    bus.stall       = 1'b0;
    bus.op          = 4'd0;
    bus.use_rs2     = 1'b0;
    bus.is_branch   = 1'b0;
    bus.is_jal      = 1'b0;
    bus.is_jalr     = 1'b0;
    bus.branch_type = 6'd0;
    bus.rs1_val     = 32'd0;
    bus.rs2_val     = 32'd0;
    bus.imm         = 32'd0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_rs2, input logic isb,
                       input logic [5:0] bt, input logic jal, input logic jalr);
    bus.valid_in    = 1'b1;
    bus.op          = op;
    bus.rs1_val     = a;
    bus.rs2_val     = b;
    bus.imm         = imm;
    bus.use_rs2     = use_rs2;
    bus.is_branch   = isb;
    bus.branch_type = bt;
    bus.is_jal      = jal;
    bus.is_jalr     = jalr;
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic use_rs2,
                       input logic isb, input logic [5:0] bt, input logic jal,
                       input logic jalr);
    logic [31:0] exp_eval;
    logic [31:0] exp_pc;
    logic        tk;
    drive(op, a, b, imm, use_rs2, isb, bt, jal, jalr);
    #1;
    exp_eval = ref_alu(op, a, use_rs2 ? b : imm);
    tk = isb && ref_taken(a, b, bt);
    if (jal || tk) exp_pc = model_pc + imm;
    else if (jalr) exp_pc = (a + imm) & 32'hFFFF_FFFE;
    else exp_pc = model_pc + 32'd4;
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_redirect"}, 32'(bus.redirect), 32'(jal || jalr || tk));
    check({tag, "_jal_addr"}, bus.jal_addr, model_pc + 32'd4);
    tick();
    check({tag, "_eval"}, bus.eval, exp_eval);
    check({tag, "_eval_valid"}, 32'(bus.eval_valid), 32'd1);
    check({tag, "_pc"}, bus.instruction_addr, exp_pc);
    model_pc   = exp_pc;
    model_eval = exp_eval;
    idle_inputs();
  endtask

  task automatic run_mdu(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall_done);
    logic [31:0] exp_eval;
    int          bc;
    int          edges;
    drive(op, a, b, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    #1;
    exp_eval = ref_alu(op, a, b);
    check({tag, "_busy_first"}, 32'(bus.busy), 32'd1);
    bc    = 0;
    edges = 0;
    while (bus.busy === 1'b1 && edges < 200) begin
      bc++;
      tick();
      edges++;
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'd33);
    check({tag, "_valid_in_done"}, 32'(bus.eval_valid), 32'd0);
    for (int i = 0; i < stall_done; i++) begin
      bus.stall = 1'b1;
      tick();
      edges++;
      check({tag, "_stall_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_stall_valid"}, 32'(bus.eval_valid), 32'd0);
      check({tag, "_stall_eval"}, bus.eval, model_eval);
      check({tag, "_stall_pc"}, bus.instruction_addr, model_pc);
    end
    bus.stall = 1'b0;
    tick();
    edges++;
    check({tag, "_eval"}, bus.eval, exp_eval);
    check({tag, "_eval_valid"}, 32'(bus.eval_valid), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(34 + stall_done));
    check({tag, "_pc"}, bus.instruction_addr, model_pc + 32'd4);
    model_pc   = model_pc + 32'd4;
    model_eval = exp_eval;
    idle_inputs();
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          kind;

    reset = 1'b0;
    idle_inputs();
    model_pc   = 32'h0;
    model_eval = 32'h0;
    #1;
    check("rst_eval", bus.eval, 32'h0);
    check("rst_valid", 32'(bus.eval_valid), 32'd0);
    check("rst_pc", bus.instruction_addr, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    issue("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    check("add_wrap_const", bus.eval, 32'h0);
    issue("sltu", 4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    check("sltu_const", bus.eval, 32'd1);
    issue("slt", 4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    check("slt_const", bus.eval, 32'd0);
    tick();
    check("idle_valid_drop", 32'(bus.eval_valid), 32'd0);

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      if (rop >= 4'd10 && rop <= 4'd13) rop = 4'($urandom_range(0, 9));
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : 32'($urandom);
      kind = $urandom_range(0, 3);
      issue("rand_alu", rop, ra, rb, 32'($urandom), 1'($urandom_range(0, 1)),
            kind == 1, 6'($urandom_range(0, 63)), kind == 2, kind == 3);
    end

    issue("jalr_to100", 4'd0, 32'h100, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    issue("bltu", 4'd0, 32'd1, 32'h8000_0000, 32'h20, 1'b1, 1'b1, 6'b010000, 1'b0, 1'b0);
    check("bltu_const", bus.instruction_addr, 32'h120);
    issue("jalr_to100b", 4'd0, 32'h100, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    issue("blt", 4'd0, 32'd1, 32'h8000_0000, 32'h20, 1'b1, 1'b1, 6'b000100, 1'b0, 1'b0);
    check("blt_const", bus.instruction_addr, 32'h104);
    issue("jalr_odd", 4'd0, 32'h201, 32'd0, 32'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    check("jalr_const", bus.instruction_addr, 32'h200);
    issue("jal", 4'd0, 32'd0, 32'd0, 32'h40, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0);
    issue("multi_bt", 4'd0, 32'd5, 32'd5, 32'h10, 1'b1, 1'b1, 6'b000110, 1'b0, 1'b0);

    run_mdu("mul", 4'd10, 32'h1_0000, 32'h1_0000, 0);
    check("mul_const", bus.eval, 32'h0);
    run_mdu("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, 0);
    check("mulhu_const", bus.eval, 32'h1);
    run_mdu("divu0", 4'd12, 32'd7, 32'd0, 0);
    check("divu0_const", bus.eval, 32'hFFFF_FFFF);
    run_mdu("remu0", 4'd13, 32'd7, 32'd0, 0);
    check("remu0_const", bus.eval, 32'd7);
    run_mdu("divu", 4'd12, 32'd100, 32'd7, 0);
    check("divu_const", bus.eval, 32'd14);
    run_mdu("remu", 4'd13, 32'd100, 32'd7, 0);
    check("remu_const", bus.eval, 32'd2);

    for (int i = 0; i < 6; i++) begin
      run_mdu("rand_mdu", 4'($urandom_range(10, 13)), $urandom,
              32'($urandom) >> $urandom_range(0, 31), 0);
    end

    run_mdu("stall_done", 4'd10, 32'd1234, 32'd5678, 3);

    issue("pre_reset", 4'd3, 32'h00F0, 32'h0F00, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    drive(4'd12, 32'd99, 32'd3, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check("midrun_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midrun_rst_eval", bus.eval, 32'h0);
    check("midrun_rst_valid", 32'(bus.eval_valid), 32'd0);
    check("midrun_rst_busy", 32'(bus.busy), 32'd0);
    check("midrun_rst_pc", bus.instruction_addr, 32'h0);
    idle_inputs();
    tick();
    reset = 1'b1;
    model_pc   = 32'h0;
    model_eval = 32'h0;
    tick();
    issue("post_reset", 4'd1, 32'd10, 32'd3, 32'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
    run_mdu("post_reset_mul", 4'd10, 32'd6, 32'd7, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
